// File: rtl/fpu_serial_bridge.sv
// -----------------------------------------------------------------------------
// fpu_serial_bridge
//
// Serial front end for the half-precision FPU datapath.
//  - Collects two FP_WIDTH operands over IN_LANE-bit lanes, one beat at a time.
//  - Issues a single operation to the attached add/mul core with a one-cycle
//    fpu_go strobe.
//  - Waits for fpu_done. If done does not arrive within TIMEOUT cycles, the
//    transaction is aborted.
//  - Returns the result as OUT_LANE-bit beats, least significant beat first,
//    using a ready/valid handshake.
//
// Ports
//  clock, reset          rising-edge clock, synchronous active-high reset
//  in_valid, in_start    input beat present / first beat of an operand set
//  in_a, in_b, in_op     operand slices and opcode
//                        (00 add, 01 mul, 10 sub, 11 add)
//  busy                  high whenever the FSM is not idle
//  fpu_a, fpu_b          registered operands presented to the core
//  fpu_mul, fpu_go       selects the mul path / one-cycle issue strobe
//  fpu_res, fpu_flag     core result and result-valid flag
//  fpu_done              core completion strobe
//  out_data, out_valid   result slice and its valid
//  out_ready             downstream accepts the current beat
//  out_last              final result beat
//  out_flag              captured fpu_flag (forced 0 on timeout)
//  out_err               asserted on every beat of a timed-out transaction
//
// Optional feature (macro FPU_BRIDGE_ERRCNT_EN)
//  err_count [7:0]       saturating count of timeouts
//  err_clr               one-cycle clear of err_count
// -----------------------------------------------------------------------------
module fpu_serial_bridge #(
  parameter int FP_WIDTH = 16,
  parameter int IN_LANE  = 4,
  parameter int OUT_LANE = 8,
  parameter int TIMEOUT  = 15
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  input  logic                in_start,
  input  logic [IN_LANE-1:0]  in_a,
  input  logic [IN_LANE-1:0]  in_b,
  input  logic [1:0]          in_op,
  output logic                busy,
  output logic [FP_WIDTH-1:0] fpu_a,
  output logic [FP_WIDTH-1:0] fpu_b,
  output logic                fpu_mul,
  output logic                fpu_go,
  input  logic [FP_WIDTH-1:0] fpu_res,
  input  logic                fpu_flag,
  input  logic                fpu_done,
  output logic [OUT_LANE-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last,
  output logic                out_flag,
  output logic                out_err
`ifdef FPU_BRIDGE_ERRCNT_EN
  ,
  input  logic                err_clr,
  output logic [7:0]          err_count
`endif
);

  localparam int IBEATS = FP_WIDTH / IN_LANE;
  localparam int OBEATS = FP_WIDTH / OUT_LANE;
  localparam int ICW    = (IBEATS > 1) ? $clog2(IBEATS) : 1;
  localparam int OCW    = (OBEATS > 1) ? $clog2(OBEATS) : 1;
  localparam int TCW    = $clog2(TIMEOUT + 1);
  localparam logic [ICW-1:0] I_LAST = ICW'(IBEATS - 1);
  localparam logic [OCW-1:0] O_LAST = OCW'(OBEATS - 1);
  localparam logic [TCW-1:0] T_LAST = TCW'(TIMEOUT - 1);

  if ((FP_WIDTH % IN_LANE) != 0 || (FP_WIDTH % OUT_LANE) != 0 || TIMEOUT < 1) begin : g_bad_cfg
    $error("fpu_serial_bridge: FP_WIDTH must be a multiple of both lanes and TIMEOUT >= 1");
  end

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_SEND} state_e;

  state_e              state_q, state_d;
  logic [ICW-1:0]      in_cnt_q, in_cnt_d;
  logic [OCW-1:0]      out_cnt_q, out_cnt_d;
  logic [TCW-1:0]      tmo_q, tmo_d;
  logic [FP_WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [1:0]          op_q, op_d;
  logic [FP_WIDTH-1:0] fpu_a_q, fpu_a_d, fpu_b_q, fpu_b_d;
  logic                fpu_mul_q, fpu_mul_d;
  logic [FP_WIDTH-1:0] res_q, res_d;
  logic                flag_q, flag_d, err_q, err_d;

  logic           capture, last_in, done_evt, timeout_evt, send_done;
  logic [ICW-1:0] beat_idx;

  // Event decode shared by the FSM and the datapath.
  always_comb begin
    capture     = in_valid && ((state_q == S_IDLE && in_start) || state_q == S_LOAD);
    beat_idx    = in_start ? '0 : in_cnt_q;
    last_in     = capture && (beat_idx == I_LAST);
    done_evt    = fpu_done && (state_q == S_ISSUE || state_q == S_WAIT);
    // Done wins over a timeout that lands in the same cycle. Counting starts
    // at 0 on the first WAIT cycle, so WAIT lasts at most TIMEOUT cycles.
    timeout_evt = (state_q == S_WAIT) && !fpu_done && (tmo_q == T_LAST);
    send_done   = (state_q == S_SEND) && out_ready && (out_cnt_q == O_LAST);
  end

  // NOTE: state registers use non-blocking assignments so that every flop
  // samples the pre-edge values of the others.
  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (capture) state_d = last_in ? S_ISSUE : S_LOAD;
      S_LOAD:  if (last_in) state_d = S_ISSUE;
      S_ISSUE: state_d = done_evt ? S_SEND : S_WAIT;
      S_WAIT:  if (done_evt || timeout_evt) state_d = S_SEND;
      S_SEND:  if (send_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values.
  always_comb begin
    // NOTE: every signal assigned in this block gets a default first; a path
    // that left one unassigned would infer a latch.
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    tmo_d     = '0;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    fpu_a_d   = fpu_a_q;
    fpu_b_d   = fpu_b_q;
    fpu_mul_d = fpu_mul_q;
    res_d     = res_q;
    flag_d    = flag_q;
    err_d     = err_q;

    if (capture) begin
      if (in_start) begin
        // A start beat discards any partial operand set.
        a_d  = '0;
        b_d  = '0;
        op_d = in_op;
      end
      a_d[beat_idx*IN_LANE +: IN_LANE] = in_a;
      b_d[beat_idx*IN_LANE +: IN_LANE] = in_b;
      in_cnt_d = last_in ? '0 : beat_idx + 1'b1;
    end

    // Core operands are latched on the way into ISSUE. They then stay
    // constant until the result has been fully delivered.
    if (last_in) begin
      fpu_a_d   = a_d;
      fpu_b_d   = b_d;
      fpu_mul_d = (op_d == 2'b01);
      if (op_d == 2'b10) fpu_b_d[FP_WIDTH-1] = ~b_d[FP_WIDTH-1];
    end else if (send_done) begin
      fpu_a_d   = '0;
      fpu_b_d   = '0;
      fpu_mul_d = 1'b0;
    end

    if (state_q == S_WAIT && !fpu_done && !timeout_evt) tmo_d = tmo_q + 1'b1;

    if (done_evt) begin
      res_d  = fpu_res;
      flag_d = fpu_flag;
      err_d  = 1'b0;
    end else if (timeout_evt) begin
      res_d  = '0;
      flag_d = 1'b0;
      err_d  = 1'b1;
    end

    if (state_q == S_SEND && out_ready) out_cnt_d = send_done ? '0 : out_cnt_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      tmo_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      fpu_a_q   <= '0;
      fpu_b_q   <= '0;
      fpu_mul_q <= 1'b0;
      res_q     <= '0;
      flag_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      tmo_q     <= tmo_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      fpu_a_q   <= fpu_a_d;
      fpu_b_q   <= fpu_b_d;
      fpu_mul_q <= fpu_mul_d;
      res_q     <= res_d;
      flag_q    <= flag_d;
      err_q     <= err_d;
    end
  end

  // Outputs. Result-side signals are gated to zero outside SEND.
  always_comb begin
    busy      = (state_q != S_IDLE);
    fpu_go    = (state_q == S_ISSUE);
    fpu_a     = fpu_a_q;
    fpu_b     = fpu_b_q;
    fpu_mul   = fpu_mul_q;
    out_valid = (state_q == S_SEND);
    out_data  = out_valid ? res_q[out_cnt_q*OUT_LANE +: OUT_LANE] : '0;
    out_last  = out_valid && (out_cnt_q == O_LAST);
    out_flag  = out_valid && flag_q;
    out_err   = out_valid && err_q;
  end

`ifdef FPU_BRIDGE_ERRCNT_EN
  logic [7:0] err_count_q, err_count_d;

  // A clear and a timeout in the same cycle leave the count at 1.
  always_comb begin
    err_count_d = err_count_q;
    if (err_clr)                                  err_count_d = {7'd0, timeout_evt};
    else if (timeout_evt && err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) err_count_q <= '0;
    else       err_count_q <= err_count_d;
  end

  assign err_count = err_count_q;
`endif

endmodule
